// File: rtl/mp_add_seq.sv
// Word-serial multi-precision add/subtract sequencer.
// LSW-first operand stream in, registered sum words out, carry chained across beats.
`timescale 1ns/1ps

module rca #(
  parameter int width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] s,
  output logic             cout
);

  logic [width:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < width; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[width];

endmodule

module mp_add_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic             carry_q;
  logic             sub_q;
  logic [CNT_W-1:0] idx_q;

  logic             accept;
  logic             sub_eff;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             c_msb;
  logic             err;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign sub_eff = in_first ? in_sub : sub_q;
  assign b_eff   = in_b ^ {WIDTH{sub_eff}};
  assign cin     = in_first ? sub_eff : carry_q;
  assign idx     = in_first ? '0 : idx_q;

  rca #(.width(WIDTH)) u_rca (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  // carry into the MSB, for signed overflow
  assign c_msb = in_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ s[WIDTH-1];

  assign err = in_first ? (state == BUSY) : (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_s     <= s;
      out_idx   <= idx;
      out_last  <= in_last;
      out_cout  <= in_last & cout;
      out_ovf   <= in_last & (cout ^ c_msb);
      out_err   <= err;
      carry_q   <= cout;
      idx_q     <= idx + CNT_W'(1);
      if (in_first) sub_q <= in_sub;
      state     <= in_last ? IDLE : BUSY;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: prefix-integer model, scoreboard compare,
// plus literal pins on the drained word log.
`timescale 1ns/1ps

module tb_mp_add_seq;

  typedef struct packed {
    logic [7:0] s;
    logic [3:0] idx;
    logic       last;
    logic       cout;
    logic       ovf;
    logic       err;
  } word_t;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] in_a = 0;
  logic [7:0] in_b = 0;
  logic       in_first = 0;
  logic       in_last = 0;
  logic       in_sub = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [7:0] out_s;
  logic [3:0] out_idx;
  logic       out_last;
  logic       out_cout;
  logic       out_ovf;
  logic       out_err;

  int tests = 0;
  int fails = 0;

  word_t exp_q[$];
  word_t got_q[$];

  longint unsigned pa, pb;
  int              mk;
  bit              msub;
  bit              mbusy;

  mp_add_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Whole-operand arithmetic on the prefix of words seen so far
  task automatic model_beat();
    longint unsigned beff, r, mask;
    int    n;
    bit    sa, sb, sr, co, ov;
    word_t w;
    w.err = in_first ? mbusy : !mbusy;
    if (in_first) begin
      pa = 0; pb = 0; mk = 0; msub = in_sub;
    end
    pa   = pa | (longint'(in_a) << (8 * mk));
    pb   = pb | (longint'(in_b) << (8 * mk));
    n    = 8 * (mk + 1);
    mask = (longint'(1) << n) - 1;
    beff = msub ? (~pb & mask) : pb;
    r    = pa + beff + longint'(msub);
    sa   = pa[n-1];
    sb   = beff[n-1];
    sr   = r[n-1];
    co   = r[n];
    ov   = (sa == sb) && (sr != sa);
    w.s    = 8'((r >> (8 * mk)) & 64'hFF);
    w.idx  = 4'(mk);
    w.last = in_last;
    w.cout = in_last & co;
    w.ovf  = in_last & ov;
    exp_q.push_back(w);
    mk++;
    mbusy = !in_last;
  endtask

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({out_s, out_idx, out_last, out_cout, out_ovf, out_err});
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (rst_n && in_valid && in_ready) model_beat();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 0, 1);
        end else begin
          chk("out_s",    out_s,    exp_q[0].s);
          chk("out_idx",  out_idx,  exp_q[0].idx);
          chk("out_last", out_last, exp_q[0].last);
          chk("out_cout", out_cout, exp_q[0].cout);
          chk("out_ovf",  out_ovf,  exp_q[0].ovf);
          chk("out_err",  out_err,  exp_q[0].err);
        end
      end else if (exp_q.size() != 0) begin
        chk("latency_out_valid", 0, 1);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input bit f, input bit l, input bit sb);
    bit done = 0;
    @(negedge clk);
    in_valid = 1; in_a = a; in_b = b;
    in_first = f; in_last = l; in_sub = sb;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      if (in_ready) done = 1;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_s"},     out_s,     0);
    chk({nm, "_idx"},   out_idx,   0);
    chk({nm, "_flags"}, {out_last, out_cout, out_ovf, out_err}, 0);
  endtask

  task automatic chk_log(input int i, input word_t w);
    if (i >= got_q.size()) chk($sformatf("log%0d_missing", i), 0, 1);
    else chk($sformatf("log%0d", i), got_q[i], w);
  endtask

  initial begin
    pa = 0; pb = 0; mk = 0; msub = 0; mbusy = 0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;

    // T1 add 0x01FF + 0x0001, then an IDLE continuation beat
    send(8'hFF, 8'h01, 1, 0, 0);
    send(8'h01, 8'h00, 0, 1, 0);
    send(8'h10, 8'h20, 0, 1, 0);
    // T2 sub 0x0000 - 0x0001
    send(8'h00, 8'h01, 1, 0, 1);
    send(8'h00, 8'h00, 0, 1, 1);
    // T3 single word 0x7F + 0x01
    send(8'h7F, 8'h01, 1, 1, 0);
    // T4 0x80FFFF + 0x7F0001 with backpressure mid-operand
    fork
      begin
        send(8'hFF, 8'h01, 1, 0, 0);
        send(8'hFF, 8'h00, 0, 0, 0);
        send(8'h80, 8'h7F, 0, 1, 0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        out_ready = 0;
        repeat (3) @(negedge clk);
        out_ready = 1;
      end
    join
    // T5 restart on word 2 of a 3-word operand
    send(8'h10, 8'h20, 1, 0, 0);
    send(8'hF0, 8'h20, 1, 0, 0);
    send(8'h01, 8'h01, 0, 1, 0);
    idle();
    repeat (4) @(negedge clk);

    // T6 reset while BUSY with a held output word
    out_ready = 0;
    send(8'h11, 8'h22, 1, 0, 0);
    idle();
    chk("t6_busy_valid", out_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk_zero("t6_async");
    exp_q.delete();
    mbusy = 0;
    @(negedge clk);
    out_ready = 1;
    rst_n = 1;
    send(8'h05, 8'h06, 1, 1, 0);
    idle();
    repeat (4) @(negedge clk);

    // literal pins: {s, idx, last, cout, ovf, err}
    chk("log_count", got_q.size(), 13);
    chk_log(0,  {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk_log(1,  {8'h02, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk_log(2,  {8'h30, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1});
    chk_log(3,  {8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk_log(4,  {8'hFF, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk_log(5,  {8'h80, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    chk_log(6,  {8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk_log(7,  {8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk_log(8,  {8'h00, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0});
    chk_log(9,  {8'h30, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk_log(10, {8'h10, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk_log(11, {8'h03, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk_log(12, {8'h0B, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
